// File: rtl/game_pkg.sv
// Shared game definitions: state bus encodings seen by the round timer and
// display, plus default gameplay constants.
package game_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'b000,
        ST_PLAY  = 3'b001,
        ST_STOP  = 3'b010,
        ST_SCORE = 3'b011,
        ST_SPEED = 3'b100,
        ST_MISS  = 3'b101
    } state_e;

    localparam int unsigned LIVES_DEF       = 3;
    localparam int unsigned SPEED_TICKS_DEF = 5;
    localparam int unsigned MISS_TICKS_DEF  = 2;
    localparam int unsigned STOP_TICKS_DEF  = 3;
    localparam int unsigned SCORE_MAX_DEF   = 999;

    // Add in 11 bits so the carry out of 10 bits is never lost, then clamp.
    function automatic logic [9:0] sat_add(input logic [9:0] a,
                                           input logic [1:0] inc,
                                           input logic [9:0] max);
        logic [10:0] s;
        s = {1'b0, a} + {9'b0, inc};
        return (s > {1'b0, max}) ? max : s[9:0];
    endfunction

endpackage

// File: rtl/game_flow_ctrl_phase_timer.sv
// Load / decrement-on-tick counter timing SPEED, MISS and STOP.
module phase_timer
    import game_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       tick,
    output logic [3:0] cnt,
    output logic       done
);

    logic [3:0] cnt_q;

    // Load wins over tick, so a tick on the entry edge is not counted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= 4'd0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (tick && cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
        end
    end

    assign cnt  = cnt_q;
    assign done = tick && (cnt_q == 4'd1);

endmodule

// File: rtl/game_flow_ctrl.sv
// Top-level game sequencer: IDLE -> PLAY -> STOP -> SCORE, with SPEED and MISS
// detours, event arbitration, score / best score / lives tracking.
module game_flow_ctrl
    import game_pkg::*;
#(
    parameter int unsigned LIVES       = LIVES_DEF,
    parameter int unsigned SPEED_TICKS = SPEED_TICKS_DEF,
    parameter int unsigned MISS_TICKS  = MISS_TICKS_DEF,
    parameter int unsigned STOP_TICKS  = STOP_TICKS_DEF,
    parameter int unsigned SCORE_MAX   = SCORE_MAX_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       start_pulse,
    input  logic       stop_tag,
    input  logic       miss_pulse,
    input  logic       hit_pulse,
    input  logic       speed_pulse,
    output logic [2:0] state,
    output logic [9:0] score,
    output logic [9:0] best_score,
    output logic [1:0] lives,
    output logic [3:0] phase_cnt,
    output logic       spawn_en,
    output logic       game_over_pulse
);

    state_e     state_q, state_d;
    logic [9:0] score_q, score_d, best_q;
    logic [1:0] lives_q, lives_d;
    logic       spawn_q, gop_q;
    logic       ld, reload, done;
    logic [3:0] ld_val;

    always_comb begin
        state_d = state_q;
        score_d = score_q;
        lives_d = lives_q;
        reload  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_pulse) begin
                    state_d = ST_PLAY;
                    score_d = 10'd0;
                    lives_d = 2'(LIVES);
                end
            end
            ST_PLAY, ST_SPEED: begin
                // Hits score even when a higher-priority event leaves the state.
                if (hit_pulse)
                    score_d = sat_add(score_q, (state_q == ST_SPEED) ? 2'd2 : 2'd1,
                                      10'(SCORE_MAX));
                if (stop_tag) begin
                    state_d = ST_STOP;
                end else if (miss_pulse) begin
                    if (lives_q <= 2'd1) begin
                        lives_d = 2'd0;
                        state_d = ST_STOP;
                    end else begin
                        lives_d = lives_q - 2'd1;
                        state_d = ST_MISS;
                    end
                end else if (speed_pulse) begin
                    state_d = ST_SPEED;
                    reload  = 1'b1;
                end else if (state_q == ST_SPEED && done) begin
                    state_d = ST_PLAY;
                end
            end
            ST_MISS: begin
                if (stop_tag)  state_d = ST_STOP;
                else if (done) state_d = ST_PLAY;
            end
            ST_STOP: begin
                if (done) state_d = ST_SCORE;
            end
            ST_SCORE: begin
                if (start_pulse) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Timer reloads on every state change; untimed states park it at 0.
    always_comb begin
        ld = (state_d != state_q) || reload;
        case (state_d)
            ST_SPEED: ld_val = 4'(SPEED_TICKS);
            ST_MISS:  ld_val = 4'(MISS_TICKS);
            ST_STOP:  ld_val = 4'(STOP_TICKS);
            default:  ld_val = 4'd0;
        endcase
    end

    phase_timer u_phase_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (ld),
        .load_val (ld_val),
        .tick     (tick),
        .cnt      (phase_cnt),
        .done     (done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            score_q <= 10'd0;
            best_q  <= 10'd0;
            lives_q <= 2'd0;
            spawn_q <= 1'b0;
            gop_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            score_q <= score_d;
            lives_q <= lives_d;
            spawn_q <= (state_d == ST_PLAY) || (state_d == ST_SPEED);
            gop_q   <= (state_d == ST_STOP) && (state_q != ST_STOP);
            if (state_q == ST_STOP && state_d == ST_SCORE && score_q > best_q)
                best_q <= score_q;
        end
    end

    assign state           = state_q;
    assign score           = score_q;
    assign best_score      = best_q;
    assign lives           = lives_q;
    assign spawn_en        = spawn_q;
    assign game_over_pulse = gop_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed bench for game_flow_ctrl with hand-computed expectations.
module tb_game_flow_ctrl;

    logic       clk = 1'b0, rst = 1'b1;
    logic       tick = 1'b0, start_pulse = 1'b0, stop_tag = 1'b0;
    logic       miss_pulse = 1'b0, hit_pulse = 1'b0, speed_pulse = 1'b0;
    logic [2:0] state;
    logic [9:0] score, best_score;
    logic [1:0] lives;
    logic [3:0] phase_cnt;
    logic       spawn_en, game_over_pulse;

    int n_chk = 0, n_err = 0;

    game_flow_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .tick            (tick),
        .start_pulse     (start_pulse),
        .stop_tag        (stop_tag),
        .miss_pulse      (miss_pulse),
        .hit_pulse       (hit_pulse),
        .speed_pulse     (speed_pulse),
        .state           (state),
        .score           (score),
        .best_score      (best_score),
        .lives           (lives),
        .phase_cnt       (phase_cnt),
        .spawn_en        (spawn_en),
        .game_over_pulse (game_over_pulse)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // One clock with the given pulses; returns 1 time unit after the edge.
    task automatic step(input bit tk, input bit st, input bit sg, input bit ms,
                        input bit ht, input bit sp);
        tick = tk; start_pulse = st; stop_tag = sg;
        miss_pulse = ms; hit_pulse = ht; speed_pulse = sp;
        @(posedge clk);
        #1;
        tick = 0; start_pulse = 0; stop_tag = 0;
        miss_pulse = 0; hit_pulse = 0; speed_pulse = 0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0);
    endtask

    initial begin
        // Reset state
        step(0, 1, 0, 0, 1, 0);
        step(0, 1, 0, 0, 1, 0);
        chk("rst_state", state, 0);
        chk("rst_score", score, 0);
        chk("rst_best", best_score, 0);
        chk("rst_lives", lives, 0);
        chk("rst_phase", phase_cnt, 0);
        chk("rst_spawn", spawn_en, 0);
        chk("rst_gop", game_over_pulse, 0);
        rst = 1'b0;

        // IDLE ignores gameplay inputs
        step(1, 0, 1, 1, 1, 1);
        chk("idle_hold", state, 0);
        chk("idle_score", score, 0);

        // Start and scoring
        step(0, 1, 0, 0, 0, 0);
        chk("start_state", state, 1);
        chk("start_lives", lives, 3);
        chk("start_spawn", spawn_en, 1);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, 0);
        chk("play_score3", score, 3);

        // Speed boost: tick on the entry edge is not counted
        step(1, 0, 0, 0, 0, 1);
        chk("speed_state", state, 4);
        chk("speed_phase", phase_cnt, 5);
        step(0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1, 0);
        chk("speed_score", score, 7);
        ticks(2);
        chk("speed_dec", phase_cnt, 3);
        step(0, 0, 0, 0, 0, 1);
        chk("speed_reload", phase_cnt, 5);
        ticks(4);
        chk("speed_last_state", state, 4);
        chk("speed_last_phase", phase_cnt, 1);
        ticks(1);
        chk("speed_exit_state", state, 1);
        chk("speed_exit_phase", phase_cnt, 0);

        // Miss handling
        step(0, 0, 0, 1, 0, 0);
        chk("miss_state", state, 5);
        chk("miss_lives", lives, 2);
        chk("miss_phase", phase_cnt, 2);
        chk("miss_spawn", spawn_en, 0);
        step(0, 0, 0, 0, 1, 1);
        chk("miss_hit_ignored", score, 7);
        chk("miss_speed_ignored", state, 5);
        ticks(1);
        chk("miss_mid", state, 5);
        ticks(1);
        chk("miss_exit", state, 1);
        chk("miss_exit_spawn", spawn_en, 1);

        // Down to one life, then last-life miss with speed and hit together
        step(0, 0, 0, 1, 0, 0);
        chk("miss2_lives", lives, 1);
        ticks(2);
        chk("miss2_exit", state, 1);
        step(0, 0, 0, 1, 1, 1);
        chk("last_state", state, 2);
        chk("last_lives", lives, 0);
        chk("last_score", score, 8);
        chk("last_gop", game_over_pulse, 1);
        chk("last_phase", phase_cnt, 3);
        step(0, 0, 0, 0, 1, 0);
        chk("gop_one_cycle", game_over_pulse, 0);
        chk("stop_hit_ignored", score, 8);
        ticks(2);
        chk("stop_hold", state, 2);
        ticks(1);
        chk("score_state", state, 3);
        chk("score_best", best_score, 8);
        chk("score_phase", phase_cnt, 0);
        step(0, 1, 0, 0, 0, 0);
        chk("back_idle", state, 0);

        // Second, lower game: stop_tag beats miss, best unchanged
        step(0, 1, 0, 0, 0, 0);
        chk("g2_state", state, 1);
        chk("g2_score", score, 0);
        chk("g2_lives", lives, 3);
        step(0, 0, 0, 0, 1, 0);
        step(0, 0, 1, 1, 0, 0);
        chk("g2_stop", state, 2);
        chk("g2_lives_kept", lives, 3);
        chk("g2_gop", game_over_pulse, 1);
        ticks(3);
        chk("g2_score_state", state, 3);
        chk("g2_best_kept", best_score, 8);
        step(0, 1, 0, 0, 0, 0);

        // Saturation at 999, then async reset mid-SPEED
        step(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 998; i++) step(0, 0, 0, 0, 1, 0);
        chk("sat_998", score, 998);
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1, 0);
        chk("sat_first", score, 999);
        step(0, 0, 0, 0, 1, 0);
        chk("sat_second", score, 999);
        chk("sat_in_speed", state, 4);
        rst = 1'b1;
        #2;
        chk("arst_state", state, 0);
        chk("arst_score", score, 0);
        chk("arst_best", best_score, 0);
        chk("arst_lives", lives, 0);
        chk("arst_phase", phase_cnt, 0);
        chk("arst_spawn", spawn_en, 0);
        chk("arst_gop", game_over_pulse, 0);
        step(0, 0, 0, 0, 0, 0);
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
